// File: rtl/alu_seq.sv
// Registered integer ALU with valid/ready handshake on both sides.
// Define ALU_SEQ_MUL_EN to enable the iterative shift-add multiplier (op 111).
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL = OPW'(6);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [OPW-1:0] OP_MUL = OPW'(7);
    logic [WIDTH-1:0] mcand, mcand_d;
    logic [WIDTH-1:0] mplier, mplier_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [SHW-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] fin_acc;
    logic             is_mul;

    assign is_mul   = (op == OP_MUL);
    assign step_acc = acc + (mplier[0] ? mcand : '0);
    // Last step also folds in the top multiplier bit so all WIDTH bits count.
    assign fin_acc  = step_acc + (mplier[1] ? (mcand << 1) : '0);
`endif

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << b[SHW-1:0];
            OP_SRL:  alu_res = a >> b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state;
        result_d = result;
        zero_d   = zero;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand;
        mplier_d = mplier;
        acc_d    = acc;
        cnt_d    = cnt;
`endif
        case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (is_mul) begin
                        state_d  = BUSY;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
`else
                    begin
`endif
                        state_d  = DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end else if (state == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                cnt_d    = cnt + SHW'(1);
                if (cnt == SHW'(WIDTH - 2)) begin
                    state_d  = DONE;
                    result_d = fin_acc;
                    zero_d   = (fin_acc == '0);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
`endif
        end else begin
            state  <= state_d;
            result <= result_d;
            zero   <= zero_d;
`ifdef ALU_SEQ_MUL_EN
            mcand  <= mcand_d;
            mplier <= mplier_d;
            acc    <= acc_d;
            cnt    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (default WIDTH=64).
// MUL checks depend on whether ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [2:0]  bb_op  [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
    logic [63:0] bb_a   [4] = '{64'hF0F0, 64'h0F, 64'hFF, 64'd100};
    logic [63:0] bb_b   [4] = '{64'hFF00, 64'hF0, 64'h0F, 64'd23};
    logic [63:0] bb_exp [4] = '{64'hF000, 64'hFF, 64'hF0, 64'd123};

    initial begin
        int k;
        int busy;
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);

        issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_wrap_valid", {63'd0, out_valid}, 64'd1);
        check("add_wrap_result", result, 64'd0);
        check("add_wrap_zero", {63'd0, zero}, 64'd1);

        issue(3'd1, 64'd3, 64'd5);
        check("sub_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_zero", {63'd0, zero}, 64'd0);

        issue(3'd5, 64'd1, 64'h43);
        check("sll_result", result, 64'd8);
        issue(3'd6, 64'h8000_0000_0000_0000, 64'd63);
        check("srl_result", result, 64'd1);

        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = bb_op[i];
            a  = bb_a[i];
            b  = bb_b[i];
            check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            @(posedge clk);
            #1;
            check("b2b_valid", {63'd0, out_valid}, 64'd1);
            check("b2b_result", result, bb_exp[i]);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_drain_valid", {63'd0, out_valid}, 64'd0);

        out_ready = 1'b0;
        issue(3'd0, 64'd2, 64'd2);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_result", result, 64'd4);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("bp_retired", {63'd0, out_valid}, 64'd0);
        check("bp_idle_ready", {63'd0, in_ready}, 64'd1);

        out_ready = 1'b0;
        issue(3'd3, 64'd5, 64'd0);
        check("pre_rst_result", result, 64'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_result", result, 64'd0);
        check("async_rst_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

`ifdef ALU_SEQ_MUL_EN
        issue(3'd7, 64'd123456789, 64'd987654321);
        a    = 64'hDEAD_BEEF;
        b    = 64'h1234;
        op   = 3'd0;
        k    = 1;
        busy = 0;
        while (!out_valid && k < 200) begin
            if (!in_ready) busy++;
            @(posedge clk);
            #1;
            k++;
        end
        check("mul_latency", 64'(k), 64'd64);
        check("mul_busy_cycles", 64'(busy), 64'd63);
        check("mul_result", result, 64'd121932631112635269);
        check("mul_zero", {63'd0, zero}, 64'd0);

        issue(3'd7, 64'd3, 64'h8000_0000_0000_0001);
        k = 1;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mul_top_latency", 64'(k), 64'd64);
        check("mul_top_result", result, 64'h8000_0000_0000_0003);

        issue(3'd7, 64'd7, 64'd9);
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mul_abort_valid", {63'd0, out_valid}, 64'd0);
        check("mul_abort_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mul_abort_no_result", {63'd0, seen}, 64'd0);
`else
        issue(3'd0, 64'd1, 64'd1);
        check("pre_mul_result", result, 64'd2);
        issue(3'd7, 64'd5, 64'd6);
        check("mul_off_valid", {63'd0, out_valid}, 64'd1);
        check("mul_off_result", result, 64'd0);
        check("mul_off_zero", {63'd0, zero}, 64'd1);
        seen = 1'b0;
        k    = 0;
        busy = 0;
        check("mul_off_seen", {63'd0, seen}, 64'(k + busy));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised-width integer ALU for the datapath, extended from the 2-op 64-bit combinational ALU.
- Adds an 8-op set, a registered result, and a valid/ready handshake on both sides.
- Adds an optional iterative (multi-cycle) multiplier.
- Sits between operand fetch and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 8, power of two).
- OPW, 3, opcode width.
- SHW, $clog2(WIDTH), shift-amount bits taken from operand b (derived, do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  OPW  operation select.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered alongside result.

Behaviour:
- Reset is asynchronous and active-low (rst_n) on a single clock (clk). Reset is asynchronous in both assertion and effect on all state.
- Reset values:
  - state=IDLE; out_valid=0; result=0; zero=0; iteration counter=0; multiplier registers=0.
  - in_ready=1 after reset, because it is derived combinationally from state.
- Opcodes (all arithmetic is modulo 2^WIDTH, unsigned):
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: a << b[SHW-1:0].
  - 110 SRL: a >> b[SHW-1:0], logical.
  - 111 MUL: low WIDTH bits of a*b.
- Transfers:
  - An input is accepted on a rising edge where in_valid && in_ready.
  - An output is retired where out_valid && out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational; back-to-back ops are allowed when the consumer drains.
- FSM states: IDLE, BUSY, DONE.
  - IDLE + accept, non-MUL op: result/zero load on the same edge; go to DONE. Latency 1 cycle (out_valid high the cycle after accept).
  - IDLE + accept, MUL: latch a into multiplicand, b into multiplier, clear accumulator, counter=0; go to BUSY.
  - BUSY, each cycle:
    - If multiplier[0], accumulator += multiplicand.
    - multiplicand <<= 1; multiplier >>= 1; counter++.
    - When counter reaches WIDTH-1 on this edge's update, load result=final accumulator and go to DONE.
    - MUL latency is WIDTH cycles from accept to out_valid (64 for the default).
  - DONE: out_valid=1; result and zero are held stable until retired.
    - DONE + out_ready + no accept: go to IDLE, out_valid drops next cycle.
    - DONE + out_ready + accept: retire and accept on the same edge. A non-MUL op stays in DONE with the new result; a MUL goes to BUSY.
    - DONE + !out_ready: hold all outputs (no accept possible, since in_ready=0).
- in_ready=0 in BUSY; a/b/op changes during BUSY are ignored.
- The zero flag is computed from the value being loaded into result.
- rst_n asserted in any state (including mid-MUL) aborts the op and returns to reset values; no result is produced.
- in_valid while in_ready=0 must be held by the producer; the block does not buffer.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 111 performs the iterative multiply above, with the BUSY state and counter present.
- Undefined: no BUSY state, counter or multiplier registers. Opcode 111 completes in 1 cycle like other ops with result=0 and zero=1.

Test Plan:
- Reset: drive rst_n=0 mid-simulation -> out_valid=0, result=0, in_ready=1 immediately (async); release -> in_ready=1, state IDLE.
- ADD wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, op=000, out_ready=1 -> next cycle out_valid=1, result=0, zero=1; SUB a=3, b=5 -> result=64'hFFFF_FFFF_FFFF_FFFE, zero=0.
- Shifts: SLL a=1, b=64'h43 (amount 3) -> 8; SRL a=64'h8000_0000_0000_0000, b=63 -> 1.
- Back-to-back: out_ready=1, in_valid held for 4 ops (AND, OR, XOR, ADD) -> one result per cycle, in_ready=1 throughout.
- Backpressure: out_ready=0 after a 000 op with a=2, b=2 -> result=4 and out_valid held for 10 cycles, in_ready=0; raise out_ready -> retired, IDLE next cycle.
- MUL (ALU_SEQ_MUL_EN defined): a=123456789, b=987654321 -> in_ready=0 for 63 cycles, out_valid exactly 64 cycles after accept, result=121932631112635269. Assert rst_n mid-op at cycle 20 -> no out_valid. Without the macro: op=111 -> result=0, zero=1 after 1 cycle.
